// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life engine: grid defaults, FSM state
// type, glider seed and a row population helper.
package life_pkg;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } life_state_t;

  // Row words, row 15 first: glider at (1,0),(2,1),(0,2),(1,2),(2,2).
  localparam logic [15:0][15:0] SEED_GRID = {
    {13{16'h0000}},
    16'h0007,
    16'h0004,
    16'h0002
  };

  function automatic logic [8:0] row_popcount(input logic [15:0] row);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 9'(row[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state of one grid row from the rows above and below,
// with the columns wrapping around at both edges.
module life_row_next #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_above,
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_below,
  output logic [W-1:0] o_next
);

  for (genvar x = 0; x < W; x++) begin : g_cell
    localparam int XL = (x + W - 1) % W;
    localparam int XR = (x + 1) % W;
    logic [3:0] w_sum;

    assign w_sum = 4'(i_above[XL]) + 4'(i_above[x]) + 4'(i_above[XR])
                 + 4'(i_cur[XL])                    + 4'(i_cur[XR])
                 + 4'(i_below[XL]) + 4'(i_below[x]) + 4'(i_below[XR]);

    assign o_next[x] = (w_sum == 4'd3) || (i_cur[x] && (w_sum == 4'd2));
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine: 16x16 torus updated in place, one row per
// clock. Define LIFE_ENGINE_POPCOUNT_EN to enable the pop_count accumulator.
module life_engine
  import life_pkg::*;
#(
  parameter int GRID_W         = GRID_W_DEF,
  parameter int GRID_H         = GRID_H_DEF,
  parameter int FRAMES_PER_GEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_i,
  input  logic        wr_en,
  input  logic [3:0]  wr_x,
  input  logic [3:0]  wr_y,
  input  logic        wr_val,
  input  logic [3:0]  rd_x,
  input  logic [3:0]  rd_y,
  output logic        rd_cell,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen,
  output logic [8:0]  pop_count
);

  localparam int ROW_W = $clog2(GRID_H);
  localparam int DIV_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_H - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_GEN - 1);

  life_state_t                   r_state;
  logic [GRID_H-1:0][GRID_W-1:0] r_grid;
  logic [GRID_W-1:0]             r_prev_old;
  logic [GRID_W-1:0]             r_row0_old;
  logic [ROW_W-1:0]              r_row;
  logic [DIV_W-1:0]              r_div_cnt;
  logic                          r_pending;
  logic                          r_busy;
  logic                          r_done;
  logic [15:0]                   r_gen;

  logic              w_step_evt;
  logic              w_start;
  logic [GRID_W-1:0] w_cur;
  logic [GRID_W-1:0] w_below;
  logic [GRID_W-1:0] w_next;

  // A step that collides with a write is deferred one cycle so the
  // generation snapshot (row 15 / row 0) already includes the written cell.
  assign w_step_evt = r_pending || step_i;
  assign w_start    = (r_state == IDLE) && w_step_evt && !wr_en && (r_div_cnt == DIV_LAST);

  // Row 0 has already been overwritten by the time row 15 is computed.
  assign w_cur   = r_grid[r_row];
  assign w_below = (r_row == LAST_ROW) ? r_row0_old : r_grid[r_row + ROW_W'(1)];

  life_row_next #(.W(GRID_W)) u_row_next (
    .i_above (r_prev_old),
    .i_cur   (w_cur),
    .i_below (w_below),
    .o_next  (w_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grid    <= SEED_GRID;
      r_row     <= '0;
      r_div_cnt <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gen     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_en) begin
            r_grid[wr_y][wr_x] <= wr_val;
          end
          if (w_step_evt && wr_en) begin
            r_pending <= 1'b1;
          end else if (w_step_evt) begin
            r_pending <= 1'b0;
            if (w_start) begin
              r_div_cnt  <= '0;
              r_prev_old <= r_grid[LAST_ROW];
              r_row0_old <= r_grid[0];
              r_row      <= '0;
              r_busy     <= 1'b1;
              r_state    <= CALC;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
        end
        CALC: begin
          r_grid[r_row] <= w_next;
          r_prev_old    <= w_cur;
          r_row         <= r_row + ROW_W'(1);
          if (r_row == LAST_ROW) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_gen   <= r_gen + 16'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LIFE_ENGINE_POPCOUNT_EN
  logic [8:0] r_pop_acc;
  logic [8:0] r_pop_count;
  logic [8:0] w_row_pop;

  assign w_row_pop = row_popcount(w_next);

  // The total is published alongside the last row so it is valid in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pop_acc   <= '0;
      r_pop_count <= '0;
    end else if (w_start) begin
      r_pop_acc <= '0;
    end else if (r_state == CALC) begin
      r_pop_acc <= r_pop_acc + w_row_pop;
      if (r_row == LAST_ROW) begin
        r_pop_count <= r_pop_acc + w_row_pop;
      end
    end
  end

  assign pop_count = r_pop_count;
`else
  assign pop_count = '0;
`endif

  assign rd_cell = r_grid[rd_y][rd_x];
  assign busy    = r_busy;
  assign done    = r_done;
  assign gen     = r_gen;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine against a behavioural torus model.
module tb_life_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset  = 1'b1;
  logic       step_a = 1'b0;
  logic       step_b = 1'b0;
  logic       wr_en  = 1'b0;
  logic       wr_val = 1'b0;
  logic [3:0] wr_x   = '0;
  logic [3:0] wr_y   = '0;
  logic [3:0] rd_x   = '0;
  logic [3:0] rd_y   = '0;

  logic        rd_a, busy_a, done_a, rd_b, busy_b, done_b;
  logic [15:0] gen_a, gen_b;
  logic [8:0]  pop_a, pop_b;

  life_engine #(.FRAMES_PER_GEN(1)) u_dut_a (
    .clk(clk), .reset(reset), .step_i(step_a), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_val(wr_val), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_a),
    .busy(busy_a), .done(done_a), .gen(gen_a), .pop_count(pop_a)
  );

  life_engine #(.FRAMES_PER_GEN(3)) u_dut_b (
    .clk(clk), .reset(reset), .step_i(step_b), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_val(wr_val), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_b),
    .busy(busy_b), .done(done_b), .gen(gen_b), .pop_count(pop_b)
  );

  int n_total = 0;
  int n_bad   = 0;
  int exp_gen_a = 0;
  logic [255:0] model_a;
  logic [255:0] got;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cidx(input int x, input int y);
    return (((y % 16) + 16) % 16) * 16 + (((x % 16) + 16) % 16);
  endfunction

  // Reference generation: count the 8 torus neighbours of every cell.
  function automatic logic [255:0] life_ref(input logic [255:0] g);
    logic [255:0] nx;
    int n;
    nx = '0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) n += int'(g[cidx(x + dx, y + dy)]);
        nx[cidx(x, y)] = (n == 3) || (g[cidx(x, y)] && n == 2);
      end
    end
    return nx;
  endfunction

  function automatic logic [255:0] cells5(input int x0, y0, x1, y1, x2, y2, x3, y3, x4, y4);
    logic [255:0] v;
    v = '0;
    v[cidx(x0, y0)] = 1'b1; v[cidx(x1, y1)] = 1'b1; v[cidx(x2, y2)] = 1'b1;
    v[cidx(x3, y3)] = 1'b1; v[cidx(x4, y4)] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] pop_exp(input logic [255:0] g);
`ifdef LIFE_ENGINE_POPCOUNT_EN
    return 256'($countones(g));
`else
    return 256'(g & '0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_gen_a = 0;
  endtask

  task automatic read_grid(input bit sel_b, output logic [255:0] g);
    g = '0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        rd_x = 4'(x);
        rd_y = 4'(y);
        #1;
        g[y * 16 + x] = sel_b ? rd_b : rd_a;
      end
    end
  endtask

  task automatic load_grid(input logic [255:0] g);
    for (int i = 0; i < 256; i++) begin
      wr_en  = 1'b1;
      wr_x   = 4'(i % 16);
      wr_y   = 4'(i / 16);
      wr_val = g[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic write_cell(input int x, input int y, input logic v);
    wr_en = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_val = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_watch(input bit sel_b, input int ncyc, output bit saw);
    saw = 1'b0;
    if (sel_b) step_b = 1'b1; else step_a = 1'b1;
    tick();
    step_a = 1'b0;
    step_b = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (sel_b ? busy_b : busy_a) saw = 1'b1;
      tick();
    end
  endtask

  // Bounded wait for done; returns one cycle later so gen has updated.
  task automatic wait_done(input bit sel_b, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (sel_b ? done_b : done_a) seen = 1'b1;
      else tick();
    end
    check_val(tag, 256'(seen), 256'(1));
    tick();
  endtask

  task automatic step_a_gen(input string tag);
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    wait_done(1'b0, tag);
    model_a = life_ref(model_a);
    exp_gen_a++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] seed, g;
    bit saw;
    int first_busy, busy_cnt, done_cyc, done_cnt;
    int cx, cy;
    logic cv;

    seed = cells5(1, 0, 2, 1, 0, 2, 1, 2, 2, 2);

    // Reset state
    do_reset();
    read_grid(1'b0, got);
    check_val("rst_grid_a", got, seed);
    read_grid(1'b1, got);
    check_val("rst_grid_b", got, seed);
    check_val("rst_busy", 256'({busy_a, busy_b}), 256'(0));
    check_val("rst_done", 256'({done_a, done_b}), 256'(0));
    check_val("rst_gen", 256'({gen_a, gen_b}), 256'(0));
    check_val("rst_pop", 256'({pop_a, pop_b}), 256'(0));

    // Divider of 3: two ticks idle, third starts, tick during busy dropped
    for (int p = 0; p < 2; p++) begin
      pulse_watch(1'b1, 20, saw);
      check_val("div3_no_start", 256'(saw), 256'(0));
    end
    read_grid(1'b1, got);
    check_val("div3_grid_kept", got, seed);
    pulse_watch(1'b1, 2, saw);
    check_val("div3_start", 256'(saw), 256'(1));
    step_b = 1'b1;
    tick();
    step_b = 1'b0;
    wait_done(1'b1, "div3_done1");
    check_val("div3_gen1", 256'(gen_b), 256'(1));
    read_grid(1'b1, got);
    check_val("div3_grid1", got, life_ref(seed));
    for (int p = 0; p < 2; p++) begin
      pulse_watch(1'b1, 20, saw);
      check_val("div3_drop_not_counted", 256'(saw), 256'(0));
    end
    pulse_watch(1'b1, 2, saw);
    check_val("div3_start2", 256'(saw), 256'(1));
    wait_done(1'b1, "div3_done2");
    check_val("div3_gen2", 256'(gen_b), 256'(2));

    // Single-step timing on the divide-by-1 instance
    do_reset();
    model_a = seed;
    first_busy = -1; busy_cnt = 0; done_cyc = -1; done_cnt = 0;
    step_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) step_a = 1'b0;
      if (busy_a) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = k;
      end
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    model_a = life_ref(model_a);
    exp_gen_a = 1;
    check_val("t_busy_first", 256'(first_busy), 256'(1));
    check_val("t_busy_len", 256'(busy_cnt), 256'(16));
    check_val("t_done_cycle", 256'(done_cyc), 256'(17));
    check_val("t_done_width", 256'(done_cnt), 256'(1));
    check_val("t_gen", 256'(gen_a), 256'(1));
    read_grid(1'b0, got);
    check_val("glider_gen1_model", got, model_a);
    check_val("glider_gen1_const", got, cells5(0, 1, 2, 1, 1, 2, 2, 2, 1, 3));

    // Write colliding with the step: cell is part of the generated grid
    wr_en = 1'b1; wr_x = 4'd5; wr_y = 4'd5; wr_val = 1'b1; step_a = 1'b1;
    tick();
    wr_en = 1'b0; step_a = 1'b0;
    wait_done(1'b0, "coll_done");
    model_a[cidx(5, 5)] = 1'b1;
    model_a = life_ref(model_a);
    exp_gen_a++;
    read_grid(1'b0, got);
    check_val("coll_grid", got, model_a);

    // Write while busy is ignored
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    tick();
    tick();
    write_cell(9, 9, 1'b1);
    wait_done(1'b0, "busywr_done");
    model_a = life_ref(model_a);
    exp_gen_a++;
    read_grid(1'b0, got);
    check_val("busywr_grid", got, model_a);
    check_val("busywr_gen", 256'(gen_a), 256'(exp_gen_a));

    // Horizontal blinker across the column seam
    load_grid('0);
    write_cell(15, 0, 1'b1);
    write_cell(0, 0, 1'b1);
    write_cell(1, 0, 1'b1);
    model_a = '0;
    model_a[cidx(15, 0)] = 1'b1; model_a[cidx(0, 0)] = 1'b1; model_a[cidx(1, 0)] = 1'b1;
    step_a_gen("wrap_done");
    read_grid(1'b0, got);
    check_val("wrap_grid_model", got, model_a);
    g = '0;
    g[cidx(0, 15)] = 1'b1; g[cidx(0, 0)] = 1'b1; g[cidx(0, 1)] = 1'b1;
    check_val("wrap_grid_const", got, g);

    // Random grids, alternately with a random colliding write
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 256; i++) g[i] = ($urandom_range(0, 2) == 0);
      load_grid(g);
      model_a = g;
      if (it % 2 == 0) begin
        cx = $urandom_range(0, 15);
        cy = ($urandom_range(0, 1) == 0) ? 15 * $urandom_range(0, 1) : $urandom_range(0, 15);
        cv = 1'($urandom_range(0, 1));
        wr_en = 1'b1; wr_x = 4'(cx); wr_y = 4'(cy); wr_val = cv; step_a = 1'b1;
        tick();
        wr_en = 1'b0; step_a = 1'b0;
        wait_done(1'b0, "rand_coll_done");
        model_a[cidx(cx, cy)] = cv;
        model_a = life_ref(model_a);
        exp_gen_a++;
      end else begin
        step_a_gen("rand_done");
      end
      read_grid(1'b0, got);
      check_val("rand_grid", got, model_a);
      check_val("rand_pop", 256'(pop_a), pop_exp(model_a));
      check_val("rand_gen", 256'(gen_a), 256'(exp_gen_a));
    end

    // Reset in the middle of a generation
    step_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) step_a = 1'b0;
    end
    reset = 1'b1;
    tick();
    check_val("midrst_busy", 256'(busy_a), 256'(0));
    check_val("midrst_gen", 256'(gen_a), 256'(0));
    reset = 1'b0;
    exp_gen_a = 0;
    read_grid(1'b0, got);
    check_val("midrst_grid", got, seed);

    // Four generations from the seed
    model_a = seed;
    for (int k = 0; k < 4; k++) step_a_gen("pop_done");
    read_grid(1'b0, got);
    check_val("gen4_grid", got, model_a);
    check_val("gen4_pop", 256'(pop_a), pop_exp(model_a));
    check_val("gen4_gen", 256'(gen_a), 256'(4));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
